// File: rtl/temporizador_regressivo_pkg.sv
// rtl/temporizador_regressivo_pkg.sv - shared types and helpers for the countdown timer
// Contents: estado_t state encoding (OCIOSO, CONTANDO, FIM) and tick_width(),
// which sizes the tick prescaler counter for a given P.
package temporizador_pkg;

    typedef enum logic [1:0] {
        OCIOSO   = 2'b00,
        CONTANDO = 2'b01,
        FIM      = 2'b10
    } estado_t;

    // Width of a modulo-p counter; at least one bit so P = 1 still elaborates.
    function automatic int tick_width(input int p);
        return (p > 1) ? $clog2(p) : 1;
    endfunction

endpackage

// File: rtl/temporizador_regressivo_if.sv
// rtl/temporizador_regressivo_if.sv - control/status bundle of the countdown timer
// Signals: inicia, valor[N], pausa, cancela (controller to timer);
// Q[N], ocupado, fim, meio (timer to controller).
// Modports: master = controller side, slave = timer side.
interface temporizador_regressivo_if #(
    parameter int N = 7
);
    logic         inicia;
    logic [N-1:0] valor;
    logic         pausa;
    logic         cancela;
    logic [N-1:0] Q;
    logic         ocupado;
    logic         fim;
    logic         meio;

    modport master (
        output inicia, valor, pausa, cancela,
        input  Q, ocupado, fim, meio
    );

    modport slave (
        input  inicia, valor, pausa, cancela,
        output Q, ocupado, fim, meio
    );
endinterface

// File: rtl/temporizador_regressivo_gerador_tick.sv
// rtl/temporizador_regressivo_gerador_tick.sv - modulo-P prescaler producing a one-cycle tick
// Ports: clock, reset (sync, active-high), clear (restart count), enable (advance/qualify),
// tick (high on the enabled cycle that completes P enabled cycles; equals enable when P = 1).
module gerador_tick
    import temporizador_pkg::*;
#(
    parameter int P = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);
    localparam int W = tick_width(P);
    localparam logic [W-1:0] ULTIMO = W'(P - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = (cnt_q == ULTIMO) ? '0 : cnt_q + W'(1);
        end
    end

    // Clear priority is resolved by the consumer, so tick stays a pure function of enable/count.
    assign tick = enable && (cnt_q == ULTIMO);

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/temporizador_regressivo.sv
// rtl/temporizador_regressivo.sv - countdown timer with pause, cancel and terminal pulse
// Parameters: M (loads saturate to M-1), N (count width), P (clock cycles per tick).
// Ports: clock, reset (sync, active-high), bus (temporizador_regressivo_if.slave).
// Optional macro TEMPORIZADOR_AUTORECARGA_EN: FIM reloads the count and keeps running.
module temporizador_regressivo
    import temporizador_pkg::*;
#(
    parameter int M = 100,
    parameter int N = 7,
    parameter int P = 1
) (
    input  logic                        clock,
    input  logic                        reset,
    temporizador_regressivo_if.slave    bus
);
    localparam logic [N-1:0] MAX_CARGA = N'(M - 1);

    estado_t      estado_q, estado_d;
    logic [N-1:0] q_q, q_d;
    logic [N-1:0] loaded_q, loaded_d;
    logic         fim_q, fim_d;
    logic         ocupado_q, ocupado_d;

    logic [N-1:0] carga;
    logic         tick;
    logic         limpa_tick;
    logic         habilita_tick;

    assign carga = (bus.valor > MAX_CARGA) ? MAX_CARGA : bus.valor;

    // Pause freezes the prescaler as well, so a partially elapsed tick survives the pause.
    assign habilita_tick = (estado_q == CONTANDO) && !bus.pausa;

    gerador_tick #(.P(P)) u_gerador_tick (
        .clock  (clock),
        .reset  (reset),
        .clear  (limpa_tick),
        .enable (habilita_tick),
        .tick   (tick)
    );

    always_comb begin
        estado_d   = estado_q;
        q_d        = q_q;
        loaded_d   = loaded_q;
        limpa_tick = 1'b0;
        if (bus.cancela) begin
            estado_d   = OCIOSO;
            q_d        = '0;
            limpa_tick = 1'b1;
        end else if (bus.inicia) begin
            loaded_d   = carga;
            q_d        = carga;
            estado_d   = (carga == '0) ? FIM : CONTANDO;
            limpa_tick = 1'b1;
        end else begin
            case (estado_q)
                CONTANDO: begin
                    if (tick && (q_q != '0)) begin
                        q_d = q_q - N'(1);
                        if (q_q == N'(1)) begin
                            estado_d = FIM;
                        end
                    end
                end
                FIM: begin
`ifdef TEMPORIZADOR_AUTORECARGA_EN
                    if (loaded_q != '0) begin
                        estado_d   = CONTANDO;
                        q_d        = loaded_q;
                        limpa_tick = 1'b1;
                    end else begin
                        estado_d = OCIOSO;
                    end
`else
                    estado_d = OCIOSO;
`endif
                end
                default: begin
                    estado_d = estado_q;
                end
            endcase
        end
        fim_d     = (estado_d == FIM);
        ocupado_d = (estado_d != OCIOSO);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q  <= OCIOSO;
            q_q       <= '0;
            loaded_q  <= '0;
            fim_q     <= 1'b0;
            ocupado_q <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            q_q       <= q_d;
            loaded_q  <= loaded_d;
            fim_q     <= fim_d;
            ocupado_q <= ocupado_d;
        end
    end

    assign bus.Q       = q_q;
    assign bus.fim     = fim_q;
    assign bus.ocupado = ocupado_q;
    // loaded > 1 is exactly the case where floor(loaded/2) is nonzero.
    assign bus.meio    = (estado_q == CONTANDO) && (loaded_q > N'(1)) && (q_q == (loaded_q >> 1));
endmodule
